mult_ctrl_taint_radix: RTL and testbench
========================================

Name: mult_ctrl_taint_radix

Overview:
- Parametrised, taint-tracked control FSM for the sequential shift-add multiplier.
- Consumes STEP multiplier bits per iteration (radix 2^STEP), giving WIDTH/STEP add/shift iterations.
- Adds an abort path and busy/done handshake taint.
- Drives datapath load/clear/add/shift strobes, each paired with a 1-bit (or per-bit) taint output for information-flow analysis.

Parameters:
- WIDTH, 8, multiplier operand width in bits.
- STEP, 1, multiplier bits consumed per iteration. Must divide WIDTH; elaboration error otherwise.
- N (localparam), WIDTH/STEP, iteration count. Digit counter width is $clog2(N) (minimum 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin multiplication (sampled in IDLE only)
- start_t  in  1  taint of start
- abort  in  1  cancel operation in progress
- abort_t  in  1  taint of abort
- mult_bits  in  WIDTH  multiplier register contents from datapath
- mult_bits_t  in  WIDTH  per-bit taint of mult_bits
- busy, busy_t  out  1  operation in progress / taint
- done, done_t  out  1  product valid pulse / taint
- md_ld, md_ld_t  out  1  load multiplicand register / taint
- mr_ld, mr_ld_t  out  1  load multiplier register / taint
- rs_clear, rs_clear_t  out  1  clear result register / taint
- rs_add, rs_add_t  out  1  add digit*multiplicand into result / taint
- add_sel  out  STEP  current multiplier digit
- add_sel_t  out  STEP  per-bit taint of add_sel
- rs_shr, rs_shr_t  out  1  shift result right by STEP / taint

Behaviour:
- Reset is synchronous, active-high, clock is clk. On rst: state = IDLE, digit counter k = 0, control taint ctl_t = 0. All outputs and taints are 0 in the following cycle.
- Outputs are combinational from state, k, mult_bits and the taints. Default value of every output is 0.
- States: IDLE, INIT, ADD, SHIFT, FINAL.
- IDLE: no outputs asserted.
  - start = 1 -> INIT.
  - ctl_t <= ctl_t | start_t every IDLE cycle, whether or not start = 1.
- INIT: md_ld = mr_ld = rs_clear = busy = 1. k <= 0. -> ADD.
- ADD:
  - Digit d = mult_bits[k*STEP +: STEP]; add_sel = d; rs_add = (d != 0); busy = 1. -> SHIFT.
- SHIFT: rs_shr = busy = 1.
  - If k == N-1 -> FINAL; else k <= k+1 -> ADD.
- FINAL: done = 1 for exactly one cycle; busy = 0. -> IDLE.
- Abort:
  - abort = 1 in INIT, ADD or SHIFT -> IDLE next cycle. No done pulse; k <= 0.
  - The current-cycle outputs of the aborted state are still driven.
  - abort is ignored in IDLE and FINAL.
- start while busy or in FINAL is ignored; there is no queuing.
- Latency: start sampled at cycle t -> INIT at t+1, ADD/SHIFT pairs at t+2..t+2N+1, done at t+2N+2. Next start is accepted at t+2N+3.
- Taint rules:
  - ctl_t is sticky. It is cleared only by rst.
  - In INIT/ADD/SHIFT, ctl_t <= ctl_t | abort_t, whether or not abort = 1.
  - Every strobe taint (md_ld_t, mr_ld_t, rs_clear_t, rs_shr_t, busy_t, done_t) = ctl_t whenever its state is active, else 0.
  - In ADD: rs_add_t = ctl_t | (|digit_t), where digit_t = mult_bits_t[k*STEP +: STEP].
  - In ADD: add_sel_t = {STEP{ctl_t}} | digit_t.
  - Outside ADD, add_sel and add_sel_t are 0.
  - done_t and busy_t follow ctl_t in every cycle in which the corresponding signal could be asserted (INIT/ADD/SHIFT for busy, FINAL for done). This covers the case where a value of 0 is itself timing-dependent.
- Reset mid-operation: returns to IDLE and clears ctl_t. No done pulse.
- Boundaries:
  - STEP = WIDTH gives N = 1: one ADD, one SHIFT, then FINAL.
  - An all-zero digit still takes the ADD cycle with rs_add = 0; timing is data-independent.

Test Plan:
- WIDTH=8, STEP=1, mult_bits=8'hA5, start=1 one cycle, no taints:
  - done pulses at t+18.
  - rs_add pattern across ADD cycles = 1,0,1,0,0,1,0,1 (LSB first).
  - All _t outputs stay 0.
- WIDTH=8, STEP=2, mult_bits=8'hC6:
  - add_sel sequence = 2,1,0,3.
  - rs_add = 1,1,0,1.
  - done at t+10.
- start_t=1 with start=0 in IDLE, then an untainted start:
  - Every strobe taint = 1 for the whole operation.
  - Taints persist into the next operation until rst.
- Untainted start, mult_bits_t=8'h04, STEP=1:
  - rs_add_t = 1 and add_sel_t = 1 only in the ADD cycle with k=2.
  - All other taints are 0.
- abort=1 during SHIFT at k=3:
  - IDLE next cycle, no done pulse, busy = 0.
  - A new start then completes normally with done at its t+18.
  - Same sequence with abort_t=1: taints set from the abort cycle on.
- rst asserted during ADD with ctl_t=1:
  - All outputs and taints are 0 the next cycle.
  - start is accepted the cycle after rst deasserts.

Source files
------------

// File: rtl/mult_ctrl_taint_radix.sv
// mult_ctrl_taint_radix: radix-2^STEP shift-add multiplier control FSM with abort and taint tracking
//   clk, rst                     clock, synchronous active-high reset
//   start/start_t                begin multiply (IDLE only) and its taint
//   abort/abort_t                cancel in INIT/ADD/SHIFT and its taint
//   mult_bits/mult_bits_t        multiplier register contents and per-bit taint
//   busy, done, md_ld, mr_ld,    control strobes, each with a matching _t taint
//   rs_clear, rs_add, rs_shr
//   add_sel/add_sel_t            current multiplier digit and its per-bit taint
module mult_ctrl_taint_radix #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             start_t,
   input  logic             abort,
   input  logic             abort_t,
   input  logic [WIDTH-1:0] mult_bits,
   input  logic [WIDTH-1:0] mult_bits_t,
   output logic             busy,
   output logic             busy_t,
   output logic             done,
   output logic             done_t,
   output logic             md_ld,
   output logic             md_ld_t,
   output logic             mr_ld,
   output logic             mr_ld_t,
   output logic             rs_clear,
   output logic             rs_clear_t,
   output logic             rs_add,
   output logic             rs_add_t,
   output logic [STEP-1:0]  add_sel,
   output logic [STEP-1:0]  add_sel_t,
   output logic             rs_shr,
   output logic             rs_shr_t
);
   localparam int N  = WIDTH / STEP;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   if (WIDTH % STEP != 0) begin : g_step_chk
      $error("mult_ctrl_taint_radix: STEP must divide WIDTH");
   end
   typedef enum logic [2:0] {S_IDLE, S_INIT, S_ADD, S_SHIFT, S_FINAL} state_t;
   state_t          r_state, w_next;
   logic [KW-1:0]   r_k, w_k_next;
   logic            r_ctl_t, w_ctl_next;
   logic            w_run;
   logic [STEP-1:0] w_digit, w_digit_t;
   assign w_digit   = STEP'(mult_bits >> (r_k * STEP));
   assign w_digit_t = STEP'(mult_bits_t >> (r_k * STEP));
   assign w_run     = (r_state == S_INIT) || (r_state == S_ADD) || (r_state == S_SHIFT);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_ctl_t <= 1'b0;
      end else begin
         r_state <= w_next;
         r_k     <= w_k_next;
         r_ctl_t <= w_ctl_next;
      end
   end
   always_comb begin
      w_next     = r_state;
      w_k_next   = r_k;
      w_ctl_next = r_ctl_t;
      busy       = 1'b0;
      busy_t     = 1'b0;
      done       = 1'b0;
      done_t     = 1'b0;
      md_ld      = 1'b0;
      md_ld_t    = 1'b0;
      mr_ld      = 1'b0;
      mr_ld_t    = 1'b0;
      rs_clear   = 1'b0;
      rs_clear_t = 1'b0;
      rs_add     = 1'b0;
      rs_add_t   = 1'b0;
      add_sel    = '0;
      add_sel_t  = '0;
      rs_shr     = 1'b0;
      rs_shr_t   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // start_t accumulates even when start is low: the decision not to start is itself tainted
            w_ctl_next = r_ctl_t | start_t;
            w_next     = start ? S_INIT : S_IDLE;
         end
         S_INIT: begin
            md_ld      = 1'b1;
            md_ld_t    = r_ctl_t;
            mr_ld      = 1'b1;
            mr_ld_t    = r_ctl_t;
            rs_clear   = 1'b1;
            rs_clear_t = r_ctl_t;
            busy       = 1'b1;
            busy_t     = r_ctl_t;
            w_k_next   = '0;
            w_next     = S_ADD;
         end
         S_ADD: begin
            busy      = 1'b1;
            busy_t    = r_ctl_t;
            add_sel   = w_digit;
            add_sel_t = {STEP{r_ctl_t}} | w_digit_t;
            rs_add    = |w_digit;
            rs_add_t  = r_ctl_t | (|w_digit_t);
            w_next    = S_SHIFT;
         end
         S_SHIFT: begin
            busy     = 1'b1;
            busy_t   = r_ctl_t;
            rs_shr   = 1'b1;
            rs_shr_t = r_ctl_t;
            w_next   = (r_k == KW'(N - 1)) ? S_FINAL : S_ADD;
            w_k_next = (r_k == KW'(N - 1)) ? r_k : r_k + KW'(1);
         end
         S_FINAL: begin
            done   = 1'b1;
            done_t = r_ctl_t;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      // abort overrides only the transition; this cycle's strobes above still go out
      if (w_run) begin
         w_ctl_next = r_ctl_t | abort_t;
         w_next     = abort ? S_IDLE : w_next;
         w_k_next   = abort ? '0 : w_k_next;
      end
   end
endmodule

// File: tb/tb_mult_ctrl_taint_radix.sv
// tb_mult_ctrl_taint_radix: checks three STEP variants against a cycle-count reference model
module tb_mult_ctrl_taint_radix;
   logic clk, rst, start, start_t, abort, abort_t;
   logic [7:0] mb, mbt;
   logic busy[3], busy_t[3], done[3], done_t[3], md_ld[3], md_ld_t[3], mr_ld[3], mr_ld_t[3];
   logic rs_clear[3], rs_clear_t[3], rs_add[3], rs_add_t[3], rs_shr[3], rs_shr_t[3];
   logic [0:0] as1, ast1;
   logic [1:0] as2, ast2;
   logic [7:0] as8, ast8;
   int total = 0, bad = 0;
   bit armed = 0;
   bit m_act[3];
   int m_c[3];
   bit m_ctl[3];
   int l0, l1, l2;
   logic [7:0] pat0, rat0, ast0v, sel2, sel8;
   logic [3:0] rsa2;
   logic tnt, bt_all, ab_busy, rs_zero, md_after, mdt_after;

   mult_ctrl_taint_radix #(.WIDTH(8), .STEP(1)) u_s1 (
      .clk(clk), .rst(rst), .start(start), .start_t(start_t), .abort(abort), .abort_t(abort_t),
      .mult_bits(mb), .mult_bits_t(mbt), .busy(busy[0]), .busy_t(busy_t[0]), .done(done[0]),
      .done_t(done_t[0]), .md_ld(md_ld[0]), .md_ld_t(md_ld_t[0]), .mr_ld(mr_ld[0]), .mr_ld_t(mr_ld_t[0]),
      .rs_clear(rs_clear[0]), .rs_clear_t(rs_clear_t[0]), .rs_add(rs_add[0]), .rs_add_t(rs_add_t[0]),
      .add_sel(as1), .add_sel_t(ast1), .rs_shr(rs_shr[0]), .rs_shr_t(rs_shr_t[0]));
   mult_ctrl_taint_radix #(.WIDTH(8), .STEP(2)) u_s2 (
      .clk(clk), .rst(rst), .start(start), .start_t(start_t), .abort(abort), .abort_t(abort_t),
      .mult_bits(mb), .mult_bits_t(mbt), .busy(busy[1]), .busy_t(busy_t[1]), .done(done[1]),
      .done_t(done_t[1]), .md_ld(md_ld[1]), .md_ld_t(md_ld_t[1]), .mr_ld(mr_ld[1]), .mr_ld_t(mr_ld_t[1]),
      .rs_clear(rs_clear[1]), .rs_clear_t(rs_clear_t[1]), .rs_add(rs_add[1]), .rs_add_t(rs_add_t[1]),
      .add_sel(as2), .add_sel_t(ast2), .rs_shr(rs_shr[1]), .rs_shr_t(rs_shr_t[1]));
   mult_ctrl_taint_radix #(.WIDTH(8), .STEP(8)) u_s8 (
      .clk(clk), .rst(rst), .start(start), .start_t(start_t), .abort(abort), .abort_t(abort_t),
      .mult_bits(mb), .mult_bits_t(mbt), .busy(busy[2]), .busy_t(busy_t[2]), .done(done[2]),
      .done_t(done_t[2]), .md_ld(md_ld[2]), .md_ld_t(md_ld_t[2]), .mr_ld(mr_ld[2]), .mr_ld_t(mr_ld_t[2]),
      .rs_clear(rs_clear[2]), .rs_clear_t(rs_clear_t[2]), .rs_add(rs_add[2]), .rs_add_t(rs_add_t[2]),
      .add_sel(as8), .add_sel_t(ast8), .rs_shr(rs_shr[2]), .rs_shr_t(rs_shr_t[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int st(int i);
      return (i == 0) ? 1 : (i == 1) ? 2 : 8;
   endfunction

   // {busy,busy_t,done,done_t,md_ld,md_ld_t,mr_ld,mr_ld_t,rs_clear,rs_clear_t,rs_add,rs_add_t,rs_shr,rs_shr_t,add_sel,add_sel_t}
   function automatic logic [29:0] gotv(int i);
      logic [7:0] a, at;
      a  = (i == 0) ? {7'b0, as1} : (i == 1) ? {6'b0, as2} : as8;
      at = (i == 0) ? {7'b0, ast1} : (i == 1) ? {6'b0, ast2} : ast8;
      return {busy[i], busy_t[i], done[i], done_t[i], md_ld[i], md_ld_t[i], mr_ld[i], mr_ld_t[i],
              rs_clear[i], rs_clear_t[i], rs_add[i], rs_add_t[i], rs_shr[i], rs_shr_t[i], a, at};
   endfunction

   // model: an operation is a count c of cycles since start: 0=INIT, odd=ADD, even=SHIFT, 2N+1=FINAL
   function automatic logic [29:0] expv(int i);
      int s, n, c, j;
      logic t;
      logic [7:0] mask, d, dt, a, at;
      logic [13:0] f;
      s = st(i); n = 8 / s; c = m_c[i]; t = m_ctl[i];
      mask = 8'((1 << s) - 1);
      f = '0; a = '0; at = '0;
      if (m_act[i]) begin
         if (c == 0) begin
            f[13] = 1; f[12] = t; f[9] = 1; f[8] = t; f[7] = 1; f[6] = t; f[5] = 1; f[4] = t;
         end else if (c <= 2 * n) begin
            f[13] = 1; f[12] = t;
            if (c % 2 == 1) begin
               j = (c - 1) / 2;
               d = (mb >> (j * s)) & mask;
               dt = (mbt >> (j * s)) & mask;
               a = d;
               at = (t ? mask : 8'h00) | dt;
               f[3] = (d != 0);
               f[2] = t | (dt != 0);
            end else begin
               f[1] = 1; f[0] = t;
            end
         end else begin
            f[11] = 1; f[10] = t;
         end
      end
      return {f, a, at};
   endfunction

   task automatic mstep();
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_act[i] = 0; m_c[i] = 0; m_ctl[i] = 0;
         end else if (!m_act[i]) begin
            m_ctl[i] = m_ctl[i] | start_t;
            if (start) begin m_act[i] = 1; m_c[i] = 0; end
         end else if (m_c[i] <= 2 * (8 / st(i))) begin
            m_ctl[i] = m_ctl[i] | abort_t;
            if (abort) m_act[i] = 0; else m_c[i]++;
         end else m_act[i] = 0;
      end
      if (rst) armed = 1;
   endtask

   task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, g, e);
      end
   endtask

   initial forever begin
      @(posedge clk);
      mstep();
   end

   initial forever begin
      @(negedge clk);
      if (armed) for (int i = 0; i < 3; i++) chk($sformatf("cycle_dut%0d", i), {2'b0, gotv(i)}, {2'b0, expv(i)});
   end

   task automatic run_op(input logic [7:0] m, input logic [7:0] mt, input int ab, input logic abt, input int rc);
      mb = m; mbt = mt; start = 1;
      @(posedge clk); #1 start = 0;
      l0 = -1; l1 = -1; l2 = -1; pat0 = 0; rat0 = 0; ast0v = 0; sel2 = 0; sel8 = 0; rsa2 = 0;
      tnt = 0; bt_all = 1; ab_busy = 1; rs_zero = 0; md_after = 0; mdt_after = 1;
      for (int cy = 1; cy <= 30; cy++) begin
         if (done[0] && l0 < 0) l0 = cy;
         if (done[1] && l1 < 0) l1 = cy;
         if (done[2] && l2 < 0) l2 = cy;
         if (cy % 2 == 0 && cy <= 16) begin
            pat0 = {rs_add[0], pat0[7:1]}; rat0 = {rs_add_t[0], rat0[7:1]}; ast0v = {ast1[0], ast0v[7:1]};
         end
         if (cy % 2 == 0 && cy <= 8) begin sel2 = {sel2[5:0], as2}; rsa2 = {rsa2[2:0], rs_add[1]}; end
         if (cy == 2) sel8 = as8;
         if (cy <= 18) tnt = tnt | busy_t[0] | done_t[0] | md_ld_t[0] | mr_ld_t[0] | rs_clear_t[0] | rs_add_t[0] | rs_shr_t[0] | ast1[0];
         if (busy[0] && !busy_t[0]) bt_all = 0;
         if (ab > 0 && cy == ab) begin abort = 1; abort_t = abt; end
         if (ab > 0 && cy == ab + 1) begin abort = 0; abort_t = 0; end
         if (ab > 0 && cy == ab + 2) ab_busy = busy[0];
         if (rc > 0 && cy == rc) rst = 1;
         if (rc > 0 && cy == rc + 1) begin rs_zero = ((gotv(0) | gotv(1) | gotv(2)) == 0); rst = 0; start = 1; end
         if (rc > 0 && cy == rc + 2) begin start = 0; md_after = md_ld[0]; mdt_after = md_ld_t[0]; end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1; start = 0; start_t = 0; abort = 0; abort_t = 0; mb = 0; mbt = 0;
      repeat (2) @(posedge clk);
      #1 chk("reset_outputs", {2'b0, gotv(0) | gotv(1) | gotv(2)}, 32'h0);
      rst = 0;
      run_op(8'hA5, 8'h00, 0, 0, 0);
      chk("a5_done_lat_s1", l0, 18);
      chk("a5_rs_add_s1", pat0, 8'hA5);
      chk("a5_done_lat_s8", l2, 4);
      chk("a5_sel_s8", sel8, 8'hA5);
      chk("a5_no_taint", tnt, 0);
      run_op(8'hC6, 8'h00, 0, 0, 0);
      chk("c6_sel_seq_s2", sel2, 8'h93);
      chk("c6_rs_add_s2", rsa2, 4'hD);
      chk("c6_done_lat_s2", l1, 10);
      chk("c6_rs_add_s1", pat0, 8'hC6);
      run_op(8'h5A, 8'h04, 0, 0, 0);
      chk("mbt04_rs_add_t", rat0, 8'h04);
      chk("mbt04_add_sel_t", ast0v, 8'h04);
      run_op(8'h3C, 8'h00, 9, 0, 0);
      chk("abort_busy_low", ab_busy, 0);
      chk("abort_no_done", l0, -1);
      run_op(8'h3C, 8'h00, 0, 0, 0);
      chk("after_abort_lat", l0, 18);
      chk("after_abort_clean", tnt, 0);
      run_op(8'h3C, 8'h00, 9, 1, 0);
      chk("abort_t_no_done", l0, -1);
      run_op(8'h3C, 8'h00, 0, 0, 0);
      chk("abort_t_sticky_busy_t", bt_all, 1);
      chk("abort_t_sticky_any", tnt, 1);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0; start_t = 1;
      @(posedge clk); #1 start_t = 0;
      run_op(8'h81, 8'h00, 0, 0, 0);
      chk("start_t_busy_t", bt_all, 1);
      run_op(8'h00, 8'h00, 0, 0, 0);
      chk("start_t_persist", bt_all, 1);
      chk("zero_digits_lat", l0, 18);
      run_op(8'hFF, 8'h00, 0, 0, 2);
      chk("rst_mid_all_zero", rs_zero, 1);
      chk("rst_then_start_md_ld", md_after, 1);
      chk("rst_then_start_md_ld_t", mdt_after, 0);
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom % 200 == 0);
         start = ($urandom % 4 == 0);
         start_t = ($urandom % 50 == 0);
         abort = ($urandom % 40 == 0);
         abort_t = ($urandom % 60 == 0);
         mb = 8'($urandom);
         mbt = ($urandom % 4 == 0) ? 8'($urandom) : 8'h00;
         @(posedge clk); #1;
      end
      rst = 0; start = 0; abort = 0; start_t = 0; abort_t = 0;
      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
